// File: rtl/lbp_hist_if.sv
// LBP sample input, histogram readout stream and status outputs of lbp_hist.
// The master side drives samples and hist_ready; the slave side is the histogram block.
interface lbp_hist_if;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_ready;
  logic        hist_valid;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic [13:0] total_cnt;
  logic        addr_err;
  logic        hist_done;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    input  hist_valid, hist_bin, hist_count, total_cnt, addr_err, hist_done
  );

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    output hist_valid, hist_bin, hist_count, total_cnt, addr_err, hist_done
  );
endinterface

// File: rtl/lbp_hist.sv
// 256-bin saturating histogram of LBP codes with a ready/valid bin readout.
// Define HIST_SKIP_ZERO_EN to present only nonzero bins during readout.
module lbp_hist (
  input logic        clk,
  input logic        reset,
  lbp_hist_if.slave  bus
);
  typedef enum logic [1:0] {ACC, READ, DONE} state_t;

  localparam logic [13:0] CNT_MAX = '1;

  state_t      state_q, state_d;
  logic [13:0] bins_q [256];
  logic [13:0] total_q;
  logic        addr_err_q;
  logic [7:0]  index_q, index_d;
  logic [6:0]  row, col;
  logic        border, sample_en;
  logic        hist_valid;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;

  assign row       = bus.lbp_addr[13:7];
  assign col       = bus.lbp_addr[6:0];
  assign border    = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
  assign sample_en = (state_q == ACC) && bus.lbp_valid;

`ifdef HIST_SKIP_ZERO_EN
  logic [255:0] nonzero;
  logic         cur_found, nxt_found;
  logic [7:0]   cur_idx, nxt_idx;

  // Lowest set bit of vec at or above from; from = 256 finds nothing.
  function automatic logic [8:0] first_set(input logic [255:0] vec, input logic [8:0] from);
    logic [8:0] r;
    r = '0;
    for (int i = 255; i >= 0; i--) begin
      if (vec[i] && (9'(i) >= from)) r = {1'b1, 8'(i)};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 256; i++) nonzero[i] = (bins_q[i] != '0);
  end

  assign {cur_found, cur_idx} = first_set(nonzero, {1'b0, index_q});
  assign {nxt_found, nxt_idx} = first_set(nonzero, {1'b0, cur_idx} + 9'd1);
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    index_d    = index_q;
    hist_valid = 1'b0;
    hist_bin   = '0;
    hist_count = '0;
    case (state_q)
      ACC: begin
        if (bus.finish) begin
          state_d = READ;
          index_d = '0;
        end
      end
      READ: begin
`ifdef HIST_SKIP_ZERO_EN
        if (!cur_found) begin
          state_d = DONE;
        end else begin
          hist_valid = 1'b1;
          hist_bin   = cur_idx;
          hist_count = bins_q[cur_idx];
          if (bus.hist_ready) begin
            if (nxt_found) index_d = nxt_idx;
            else           state_d = DONE;
          end
        end
`else
        hist_valid = 1'b1;
        hist_bin   = index_q;
        hist_count = bins_q[index_q];
        if (bus.hist_ready) begin
          if (index_q == 8'd255) state_d = DONE;
          else                   index_d = index_q + 8'd1;
        end
`endif
      end
      DONE:    ;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= ACC;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the bins are flops, not a RAM, because reset must clear every bin in one edge.
      for (int i = 0; i < 256; i++) bins_q[i] <= '0;
      total_q    <= '0;
      addr_err_q <= 1'b0;
    end else if (sample_en) begin
      if (bins_q[bus.lbp_data] != CNT_MAX) bins_q[bus.lbp_data] <= bins_q[bus.lbp_data] + 14'd1;
      if (total_q != CNT_MAX)              total_q <= total_q + 14'd1;
      if (border)                          addr_err_q <= 1'b1;
    end
  end

  assign bus.hist_valid = hist_valid;
  assign bus.hist_bin   = hist_bin;
  assign bus.hist_count = hist_count;
  assign bus.total_cnt  = total_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.hist_done  = (state_q == DONE);
endmodule

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 The block SHALL run on one clock and a synchronous active-low reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-low reset.
REQ-002 The block SHALL have the input lbp_valid  input  1  LBP sample strobe from the upstream LBP stage.
REQ-003 The block SHALL have the input lbp_addr  input  14  pixel address {row[13:7], col[6:0]} of the sample.
REQ-004 The block SHALL have the input lbp_data  input  8  LBP code, used as the histogram bin index.
REQ-005 The block SHALL have the input finish  input  1  end-of-image indication from upstream, level or pulse.
REQ-006 The block SHALL have the input hist_ready  input  1  downstream accepts the current bin.
REQ-007 The block SHALL have the output hist_valid  output  1  hist_bin/hist_count are valid.
REQ-008 The block SHALL have the output hist_bin  output  8  bin index being presented.
REQ-009 The block SHALL have the output hist_count  output  14  count for hist_bin.
REQ-010 The block SHALL have the output total_cnt  output  14  number of accepted samples.
REQ-011 The block SHALL have the output addr_err  output  1  sticky flag: a sample arrived with a border address.
REQ-012 The block SHALL have the output hist_done  output  1  high once readout is complete, held until reset.

Function
REQ-013 The block SHALL implement the FSM states ACC, READ and DONE, with ACC as the reset state.
REQ-014 In ACC, each cycle with lbp_valid=1 SHALL increment bin[lbp_data] and total_cnt by 1 in the same clock edge.
REQ-015 Back-to-back samples to the same bin SHALL each be counted, with no lost increments and no stall.
REQ-016 Bin counters and total_cnt SHALL saturate at 16383; this is the sole wrap-around rule.
REQ-017 A valid sample whose lbp_addr row or column equals 0 or 127 SHALL still be counted and SHALL set addr_err=1 until reset.
REQ-018 finish=1 in ACC SHALL move the FSM to READ on the next edge; a sample with lbp_valid=1 in that same cycle SHALL be counted.
REQ-019 In READ and DONE, lbp_valid SHALL be ignored and no counter SHALL change.
REQ-020 In READ, outputs SHALL be hist_valid=1, hist_bin=index register and hist_count=bin[index]; index SHALL start at 0 on READ entry.
REQ-021 A transfer SHALL occur on any cycle with hist_valid=1 and hist_ready=1; index SHALL then advance, and hist_bin/hist_count SHALL stay stable while hist_ready=0.
REQ-022 A transfer of the last bin (255) SHALL move the FSM to DONE; in DONE, hist_valid=0 and hist_done=1.
REQ-023 DONE SHALL be terminal; only reset SHALL exit DONE.
REQ-024 Outside READ, hist_bin and hist_count SHALL be 0.

Reset
REQ-025 reset=0 at a rising edge SHALL clear all 256 bins, total_cnt, addr_err, hist_done, hist_valid and the index, and SHALL force ACC.
REQ-026 Reset SHALL take effect in any state, including mid-accumulation and mid-readout; no partial transfer SHALL be completed afterwards.
REQ-027 During and after reset all outputs SHALL read 0 until new samples arrive.

Configuration
REQ-028 With macro HIST_SKIP_ZERO_EN defined, READ SHALL present only bins with a nonzero count, in ascending order; zero bins SHALL be skipped with no hist_valid cycle.
REQ-029 With HIST_SKIP_ZERO_EN defined and fewer than 256 nonzero bins, DONE SHALL follow the transfer of the highest nonzero bin; if all bins are zero, DONE SHALL be entered one cycle after READ entry.
REQ-030 With HIST_SKIP_ZERO_EN undefined, all 256 bins SHALL be presented, including zeros.

Verification
REQ-031 Test 1: drive 5 samples with code 0x3C, then 3 with code 0xFF, then finish with hist_ready=1 -> 256 transfers; bin 0x3C=5, bin 0xFF=3, all others 0; total_cnt=8; hist_done=1 after bin 255.
REQ-032 Test 2: drive 16384 samples with code 0x00 (addresses interior), then finish -> bin 0 count=16383 and total_cnt=16383 (saturated), addr_err=0.
REQ-033 Test 3: drive lbp_valid with lbp_addr=14'h0081 followed by 14'h0080 -> addr_err=0 after the first sample and 1 after the second; both samples counted, total_cnt=2.
REQ-034 Test 4: in READ, hold hist_ready=0 for 10 cycles at bin 7 -> hist_bin=7 and hist_count stable throughout; resume -> next transfer is bin 8.
REQ-035 Test 5: assert lbp_valid (code 0x11) and finish in the same cycle -> bin 0x11=1 at readout; later samples ignored.
REQ-036 Test 6: assert reset=0 at bin 100 in READ -> next cycle state=ACC, hist_valid=0, and all bins 0 on a subsequent readout; with HIST_SKIP_ZERO_EN defined and only 0x3C/0xFF nonzero, exactly 2 transfers occur.
